// File: rtl/lcd_pkg.sv
// HD44780 LCD write controller: shared states, command codes and helpers.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT
  } lcd_state_e;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_HOME     = 8'h02;

  function automatic logic [7:0] init_cmd(
    input logic [1:0] idx
  );
    logic [7:0] c;
    unique case (idx)
      2'd0: c = CMD_FUNC_SET;
      2'd1: c = CMD_DISP_ON;
      2'd2: c = CMD_CLEAR;
      2'd3: c = CMD_ENTRY;
    endcase
    return c;
  endfunction

  // Clear and home need the long execution wait.
  function automatic logic is_slow(
    input logic       rs,
    input logic [7:0] data
  );
    return !rs && (data == CMD_CLEAR ||
                   data == CMD_HOME);
  endfunction

  function automatic int imax(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable saturating down-counter; o_done marks the last cycle of a delay.
module lcd_delay_cnt #(
  parameter int unsigned   W       = 8,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= RST_VAL;
    end else if (i_load) begin
      cnt_q <= i_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign o_done = (cnt_q == W'(1));

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write-only controller: power-up init sequence, then one
// request-at-a-time byte writes with setup/pulse/hold/exec timing.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC    = 2,
  parameter int EN_CYC       = 25,
  parameter int HOLD_CYC     = 2,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 82000,
  parameter int PWR_WAIT_CYC = 2500000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_valid,
  input  logic       i_req_rs,
  input  logic [7:0] i_req_data,
  output logic       o_req_ready,
  output logic       o_busy,
  output logic       o_lcd_en,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_on
);

  localparam int MAX_CYC = imax(
    imax(imax(SETUP_CYC, EN_CYC),
         imax(HOLD_CYC, CMD_WAIT_CYC)),
    imax(CLR_WAIT_CYC, PWR_WAIT_CYC));
  localparam int CW = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] SETUP_W = CW'(SETUP_CYC);
  localparam logic [CW-1:0] EN_W    = CW'(EN_CYC);
  localparam logic [CW-1:0] HOLD_W  = CW'(HOLD_CYC);
  localparam logic [CW-1:0] CMD_W   = CW'(CMD_WAIT_CYC);
  localparam logic [CW-1:0] CLR_W   = CW'(CLR_WAIT_CYC);
  localparam logic [CW-1:0] PWR_W   = CW'(PWR_WAIT_CYC);

  lcd_state_e  state_q, state_d;
  logic        init_q, init_d;
  logic [1:0]  idx_q, idx_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        ld;
  logic [CW-1:0] ld_val;
  logic        done;
  logic        ready;

  lcd_delay_cnt #(
    .W       (CW),
    .RST_VAL (PWR_W)
  ) u_dly (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (ld),
    .i_val  (ld_val),
    .o_done (done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= PWR_WAIT;
      init_q  <= 1'b1;
      idx_q   <= 2'd0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      idx_q   <= idx_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    idx_d   = idx_q;
    rs_d    = rs_q;
    data_d  = data_q;
    ld      = 1'b0;
    ld_val  = '0;
    unique case (state_q)
      PWR_WAIT: begin
        if (done) begin
          state_d = SETUP;
          rs_d    = 1'b0;
          data_d  = init_cmd(idx_q);
          ld      = 1'b1;
          ld_val  = SETUP_W;
        end
      end
      IDLE: begin
        if (i_req_valid && !init_q) begin
          state_d = SETUP;
          rs_d    = i_req_rs;
          data_d  = i_req_data;
          ld      = 1'b1;
          ld_val  = SETUP_W;
        end
      end
      SETUP: begin
        if (done) begin
          state_d = PULSE;
          ld      = 1'b1;
          ld_val  = EN_W;
        end
      end
      PULSE: begin
        if (done) begin
          state_d = HOLD;
          ld      = 1'b1;
          ld_val  = HOLD_W;
        end
      end
      HOLD: begin
        if (done) begin
          state_d = WAIT;
          ld      = 1'b1;
          ld_val  = is_slow(rs_q, data_q)
                    ? CLR_W : CMD_W;
        end
      end
      WAIT: begin
        if (done) begin
          state_d = IDLE;
          // Chain straight into the next init command.
          if (init_q) begin
            if (idx_q == 2'd3) begin
              init_d = 1'b0;
            end else begin
              idx_d   = idx_q + 2'd1;
              data_d  = init_cmd(idx_q + 2'd1);
              rs_d    = 1'b0;
              state_d = SETUP;
              ld      = 1'b1;
              ld_val  = SETUP_W;
            end
          end
        end
      end
      default: state_d = PWR_WAIT;
    endcase
  end

  assign ready       = (state_q == IDLE) && !init_q;
  assign o_req_ready = ready;
  assign o_busy      = !ready;
  assign o_lcd_en    = (state_q == PULSE);
  assign o_lcd_rs    = rs_q;
  assign o_lcd_data  = data_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_on    = !i_rst;

endmodule
